// File: rtl/reset_seq_pkg.sv
// ============================================================================
// Module  : reset_seq_pkg
// Brief   : Shared types and defaults for the staged reset sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_ASSERT  = 2'd3
  } state_e;

  localparam int unsigned DEF_NUM_DOMAINS = 3;
  localparam int unsigned DEF_HOLD_CYCLES = 16;
  localparam int unsigned DEF_STEP_CYCLES = 4;
  localparam int unsigned DEF_CNT_W       = 8;

  localparam logic [7:0] SOFT_COUNT_MAX = 8'd255;

endpackage

`default_nettype wire

// File: rtl/reset_seq_timer.sv
// ============================================================================
// Module  : reset_seq_timer
// Brief   : Loadable down-counter; done_o is high while one cycle remains.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reset_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o,
  output logic             idle_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Stops at zero rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == CNT_W'(1));
  assign idle_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// Module  : reset_sequencer
// Brief   : Staged per-domain reset release/assert with soft-reset handshake.
//           Define RESET_SEQ_COUNT_EN to add the soft_reset_count output.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STEP_CYCLES = DEF_STEP_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   soft_reset_req,
  output logic                   soft_reset_ack,
  output logic [NUM_DOMAINS-1:0] domain_resetn,
  output logic                   running
`ifdef RESET_SEQ_COUNT_EN
  ,
  output logic [7:0]             soft_reset_count
`endif
);

  localparam int LVL_W = $clog2(NUM_DOMAINS + 1);
  localparam logic [CNT_W-1:0] C_HOLD_V = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] C_STEP_V = CNT_W'(STEP_CYCLES);

  state_e                 state_q, state_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   soft_q, soft_d;
  logic [NUM_DOMAINS-1:0] resetn_q, resetn_d;
  logic                   running_q, running_d;
  logic                   ack_q, ack_d;

  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_done;
  logic                   tmr_idle;

  reset_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done),
    .idle_o     (tmr_idle)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_HOLD;
      level_q   <= '0;
      soft_q    <= 1'b0;
      resetn_q  <= '0;
      running_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      soft_q    <= soft_d;
      resetn_q  <= resetn_d;
      running_q <= running_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    soft_d   = soft_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_HOLD: begin
        // An idle timer here means we just left reset: this edge stands in for
        // the entry edge, so the remaining hold is one cycle shorter.
        if (tmr_done || (tmr_idle && HOLD_CYCLES == 1)) begin
          level_d = LVL_W'(1);
          if (NUM_DOMAINS == 1) begin
            state_d = ST_RUN;
            soft_d  = 1'b0;
          end else begin
            state_d  = ST_RELEASE;
            tmr_load = 1'b1;
            tmr_val  = C_STEP_V;
          end
        end else if (tmr_idle) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(HOLD_CYCLES - 1);
        end
      end
      ST_RELEASE: begin
        if (tmr_done) begin
          level_d = level_q + LVL_W'(1);
          if (level_q == LVL_W'(NUM_DOMAINS - 1)) begin
            state_d = ST_RUN;
            soft_d  = 1'b0;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = C_STEP_V;
          end
        end
      end
      ST_RUN: begin
        if (soft_reset_req && !ack_q) begin
          state_d  = ST_ASSERT;
          level_d  = LVL_W'(NUM_DOMAINS - 1);
          soft_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = C_STEP_V;
        end
      end
      ST_ASSERT: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (level_q <= LVL_W'(1)) begin
            state_d = ST_HOLD;
            level_d = '0;
            tmr_val = C_HOLD_V;
          end else begin
            level_d = level_q - LVL_W'(1);
            tmr_val = C_STEP_V;
          end
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      resetn_d[i] = (LVL_W'(i) < level_d);
    end
    running_d = (state_d == ST_RUN);
    ack_d     = ack_q;
    if (ack_q && !soft_reset_req) begin
      ack_d = 1'b0;
    end
    if (state_d == ST_RUN && state_q != ST_RUN && soft_q) begin
      ack_d = 1'b1;
    end
  end

  assign domain_resetn  = resetn_q;
  assign running        = running_q;
  assign soft_reset_ack = ack_q;

`ifdef RESET_SEQ_COUNT_EN
  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (ack_d && !ack_q && count_q != SOFT_COUNT_MAX) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign soft_reset_count = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// Module  : tb_reset_sequencer
// Brief   : Directed checks of reset_sequencer in default and 1/1/1 configs.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst0, req0, ack0, run0;
  logic [2:0] rn0;
  logic       rst1, req1, ack1, run1;
  logic [0:0] rn1;
`ifdef RESET_SEQ_COUNT_EN
  logic [7:0] cnt0, cnt1;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int e           = 0;

  always #5 clk = ~clk;

  reset_sequencer dut0 (
    .clock          (clk),
    .reset          (rst0),
    .soft_reset_req (req0),
    .soft_reset_ack (ack0),
    .domain_resetn  (rn0),
    .running        (run0)
`ifdef RESET_SEQ_COUNT_EN
    ,
    .soft_reset_count (cnt0)
`endif
  );

  reset_sequencer #(
    .NUM_DOMAINS (1),
    .HOLD_CYCLES (1),
    .STEP_CYCLES (1),
    .CNT_W       (8)
  ) dut1 (
    .clock          (clk),
    .reset          (rst1),
    .soft_reset_req (req1),
    .soft_reset_ack (ack1),
    .domain_resetn  (rn1),
    .running        (run1)
`ifdef RESET_SEQ_COUNT_EN
    ,
    .soft_reset_count (cnt1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic goto(input int n);
    while (e < n) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One handshake on the single-domain instance; ok=0 if ack never arrives.
  task automatic soft1(output bit ok);
    ok   = 1'b0;
    req1 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (ack1 === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    req1 = 1'b0;
    step();
  endtask

  initial begin
    int t;
    int timeouts;
    bit ok;
    rst0 = 1'b1; req0 = 1'b0;
    rst1 = 1'b1; req1 = 1'b0;
    step(); step();
    e = 0;
    chk("rst rn0", 32'(rn0), 32'h0);
    chk("rst run0", 32'(run0), 32'h0);
    chk("rst ack0", 32'(ack0), 32'h0);
    rst0 = 1'b0;

    // Cold start
    goto(15); chk("cold e15 rn", 32'(rn0), 32'h0);
    goto(16); chk("cold e16 rn", 32'(rn0), 32'h1);
    goto(19); chk("cold e19 rn", 32'(rn0), 32'h1);
    goto(20); chk("cold e20 rn", 32'(rn0), 32'h3);
    goto(23); chk("cold e23 rn", 32'(rn0), 32'h3);
              chk("cold e23 run", 32'(run0), 32'h0);
    goto(24); chk("cold e24 rn", 32'(rn0), 32'h7);
              chk("cold e24 run", 32'(run0), 32'h1);
              chk("cold e24 ack", 32'(ack0), 32'h0);

    // Soft reset requested at edge 40
    goto(40); req0 = 1'b1;
    goto(41); chk("soft e41 rn", 32'(rn0), 32'h3);
              chk("soft e41 run", 32'(run0), 32'h0);
    goto(44); chk("soft e44 rn", 32'(rn0), 32'h3);
    goto(45); chk("soft e45 rn", 32'(rn0), 32'h1);
    goto(49); chk("soft e49 rn", 32'(rn0), 32'h0);
    goto(64); chk("soft e64 rn", 32'(rn0), 32'h0);
    goto(65); chk("soft e65 rn", 32'(rn0), 32'h1);
    goto(69); chk("soft e69 rn", 32'(rn0), 32'h3);
    goto(72); chk("soft e72 ack", 32'(ack0), 32'h0);
              chk("soft e72 run", 32'(run0), 32'h0);
    goto(73); chk("soft e73 rn", 32'(rn0), 32'h7);
              chk("soft e73 run", 32'(run0), 32'h1);
              chk("soft e73 ack", 32'(ack0), 32'h1);
    goto(78); chk("soft e78 held rn", 32'(rn0), 32'h7);
              chk("soft e78 held ack", 32'(ack0), 32'h1);
    goto(80); req0 = 1'b0;
    goto(81); chk("soft e81 ack", 32'(ack0), 32'h0);
              chk("soft e81 run", 32'(run0), 32'h1);

    // Hard reset, then a request pulse during RELEASE
    rst0 = 1'b1;
    step();   chk("rerst rn", 32'(rn0), 32'h0);
              chk("rerst run", 32'(run0), 32'h0);
    e = 0; rst0 = 1'b0;
    goto(18); req0 = 1'b1;
    goto(19); req0 = 1'b0;
    goto(24); chk("relreq e24 rn", 32'(rn0), 32'h7);
              chk("relreq e24 run", 32'(run0), 32'h1);
    goto(26); chk("relreq e26 ack", 32'(ack0), 32'h0);
              chk("relreq e26 rn", 32'(rn0), 32'h7);

    // Hard reset in the middle of a soft-reset sequence
    t = 30;
    goto(t); req0 = 1'b1;
    goto(t + 29); chk("mid t+29 rn", 32'(rn0), 32'h3);
    goto(t + 30); rst0 = 1'b1; req0 = 1'b0;
    goto(t + 31); chk("mid t+31 rn", 32'(rn0), 32'h0);
                  chk("mid t+31 run", 32'(run0), 32'h0);
                  chk("mid t+31 ack", 32'(ack0), 32'h0);
    rst0 = 1'b0;
    goto(t + 46); chk("mid t+46 rn", 32'(rn0), 32'h0);
    goto(t + 47); chk("mid t+47 rn", 32'(rn0), 32'h1);
    goto(t + 51); chk("mid t+51 rn", 32'(rn0), 32'h3);
    goto(t + 55); chk("mid t+55 rn", 32'(rn0), 32'h7);
                  chk("mid t+55 run", 32'(run0), 32'h1);
                  chk("mid t+55 ack", 32'(ack0), 32'h0);

    // Single domain, 1/1/1 timing
    e = 0;
    chk("d1 rst rn", 32'(rn1), 32'h0);
    chk("d1 rst run", 32'(run1), 32'h0);
    rst1 = 1'b0;
    goto(1); chk("d1 e1 rn", 32'(rn1), 32'h1);
             chk("d1 e1 run", 32'(run1), 32'h1);
    goto(3); req1 = 1'b1;
    goto(4); chk("d1 e4 rn", 32'(rn1), 32'h0);
             chk("d1 e4 run", 32'(run1), 32'h0);
    goto(5); chk("d1 e5 rn", 32'(rn1), 32'h0);
             chk("d1 e5 ack", 32'(ack1), 32'h0);
    goto(6); chk("d1 e6 rn", 32'(rn1), 32'h1);
             chk("d1 e6 run", 32'(run1), 32'h1);
             chk("d1 e6 ack", 32'(ack1), 32'h1);
    req1 = 1'b0;
    goto(7); chk("d1 e7 ack", 32'(ack1), 32'h0);

    // Repeated handshakes on the single-domain instance
    timeouts = 0;
    for (int n = 1; n < 3; n++) begin
      soft1(ok);
      if (!ok) timeouts++;
    end
`ifdef RESET_SEQ_COUNT_EN
    chk("count 3", 32'(cnt1), 32'd3);
    chk("count dut0", 32'(cnt0), 32'd0);
`endif
    for (int n = 3; n < 300; n++) begin
      soft1(ok);
      if (!ok) timeouts++;
    end
    chk("handshake timeouts", 32'(timeouts), 32'd0);
    chk("d1 final run", 32'(run1), 32'h1);
`ifdef RESET_SEQ_COUNT_EN
    chk("count sat", 32'(cnt1), 32'd255);
    rst1 = 1'b1;
    step();
    chk("count clr", 32'(cnt1), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
